// File: rtl/noc_input_fifo_if.sv
// Link bundle between a router input port and its neighbour/arbiters:
// RTS/CTS write handshake, per-output-arbiter pop grants and FIFO status.
interface noc_input_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] RX;
  logic                  DRTS;
  logic                  CTS;
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;

  modport master (
    output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, full, count
  );

  modport slave (
    input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, full, count
  );
endinterface

// File: rtl/noc_input_fifo.sv
// Router input-port buffer: circular FIFO filled over an RTS/CTS handshake
// and drained by the grants of the five output-port arbiters.
module noc_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic            clk,
  input logic            rst,
  noc_input_fifo_if.slave link
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_WAIT = 1'b0, ST_ACK = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      read_ptr;
  logic [PTR_W-1:0]      write_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr;
  logic                  pop;
  logic                  empty;
  logic                  full;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  // Arbiters grant one-hot, so any grant is a single pop.
  assign pop   = (link.read_en_N | link.read_en_E | link.read_en_W |
                  link.read_en_S | link.read_en_L) & ~empty;

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    case (state)
      ST_WAIT: begin
        if (link.DRTS && !full) begin
          state_nxt = ST_ACK;
          wr        = 1'b1;
        end
      end
      // Upstream still holds DRTS during the CTS cycle; skip it to avoid a double write.
      ST_ACK:  state_nxt = ST_WAIT;
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      read_ptr  <= '0;
      write_ptr <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      if (wr)  write_ptr <= write_ptr + PTR_W'(1);
      if (pop) read_ptr  <= read_ptr + PTR_W'(1);
      case ({wr, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; only a write pending on a reset edge is suppressed.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[write_ptr] <= link.RX;
  end

  assign link.CTS      = (state == ST_ACK);
  assign link.Data_out = empty ? '0 : mem[read_ptr];
  assign link.empty    = empty;
  assign link.full     = full;
  assign link.count    = count;
endmodule

// File: tb/tb_noc_input_fifo.sv
// Self-checking bench for noc_input_fifo: directed scenarios plus random
// traffic compared against a queue-based model of the buffer.
module tb_noc_input_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  noc_input_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifc ();

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Reference model: the buffered flits in order, plus whether the link is in its CTS cycle.
  logic [DW-1:0] q[$];
  bit            m_cts;

  logic [CNT_W+DW+2:0] dut_vec;
  assign dut_vec = {ifc.CTS, ifc.empty, ifc.full, ifc.count, ifc.Data_out};

  function automatic logic [CNT_W+DW+2:0] exp_vec();
    logic [DW-1:0] head;
    head = (q.size() == 0) ? '0 : q[0];
    return {m_cts, q.size() == 0, q.size() == DEPTH, CNT_W'(q.size()), head};
  endfunction

  // One clock: the model decides from the inputs held over the edge, then outputs settle.
  task automatic cyc();
    bit any_rd;
    bit do_wr;
    bit do_pop;
    logic [DW-1:0] rx;
    any_rd = ifc.read_en_N | ifc.read_en_E | ifc.read_en_W | ifc.read_en_S | ifc.read_en_L;
    do_wr  = !m_cts && ifc.DRTS && (q.size() < DEPTH);
    do_pop = any_rd && (q.size() > 0);
    rx     = ifc.RX;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cts = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_wr) q.push_back(rx);
      m_cts = do_wr;
    end
    #1;
  endtask

  task automatic clear_reads();
    ifc.read_en_N = 1'b0;
    ifc.read_en_E = 1'b0;
    ifc.read_en_W = 1'b0;
    ifc.read_en_S = 1'b0;
    ifc.read_en_L = 1'b0;
  endtask

  task automatic handshake(input logic [DW-1:0] v);
    ifc.DRTS = 1'b1;
    ifc.RX   = v;
    cyc();
    ifc.DRTS = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.DRTS = 1'b1;
    ifc.RX = 32'hDEAD_0000;
    cyc();
    cyc();
    checks++;
    if (ifc.count !== 0 || ifc.empty !== 1'b1 || ifc.full !== 1'b0 || ifc.CTS !== 1'b0 || ifc.Data_out !== '0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d empty=%b full=%b cts=%b data=%h required 0/1/0/0/0",
               ifc.count, ifc.empty, ifc.full, ifc.CTS, ifc.Data_out);
    end
    ifc.DRTS = 1'b0;
    rst = 1'b0;
    cyc();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h required %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single_flit();
    int cts_cycles;
    cts_cycles = 0;
    ifc.DRTS = 1'b1;
    ifc.RX = 32'hA5A5_0001;
    cyc();
    cts_cycles += ifc.CTS;
    checks++;
    if (ifc.count !== 1 || ifc.empty !== 1'b0 || ifc.Data_out !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_write: got cnt=%0d empty=%b data=%h required 1/0/a5a50001",
               ifc.count, ifc.empty, ifc.Data_out);
    end
    cyc();
    cts_cycles += ifc.CTS;
    ifc.DRTS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      cts_cycles += ifc.CTS;
    end
    checks++;
    if (cts_cycles != 1 || ifc.count !== 1) begin
      errors++;
      $display("FAIL single_cts: got cts_cycles=%0d cnt=%0d required 1/1", cts_cycles, ifc.count);
    end
    ifc.read_en_E = 1'b1;
    cyc();
    clear_reads();
    checks++;
    if (ifc.empty !== 1'b1 || ifc.Data_out !== '0 || ifc.count !== 0) begin
      errors++;
      $display("FAIL single_pop: got empty=%b data=%h cnt=%0d required 1/0/0",
               ifc.empty, ifc.Data_out, ifc.count);
    end
  endtask

  task automatic test_fill_full();
    int cts_seen;
    for (int v = 1; v <= 4; v++) handshake(v);
    checks++;
    if (ifc.full !== 1'b1 || ifc.count !== 4 || ifc.Data_out !== 32'd1) begin
      errors++;
      $display("FAIL fill_full: got full=%b cnt=%0d data=%h required 1/4/1", ifc.full, ifc.count, ifc.Data_out);
    end
    ifc.DRTS = 1'b1;
    ifc.RX = 32'd5;
    cts_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cts_seen += ifc.CTS;
    end
    checks++;
    if (cts_seen != 0 || ifc.count !== 4) begin
      errors++;
      $display("FAIL full_blocks: got cts_cycles=%0d cnt=%0d required 0/4", cts_seen, ifc.count);
    end
    ifc.read_en_L = 1'b1;
    cyc();
    clear_reads();
    checks++;
    if (ifc.Data_out !== 32'd2 || ifc.CTS !== 1'b0 || ifc.count !== 3) begin
      errors++;
      $display("FAIL full_pop: got data=%h cts=%b cnt=%0d required 2/0/3", ifc.Data_out, ifc.CTS, ifc.count);
    end
    cyc();
    ifc.DRTS = 1'b0;
    checks++;
    if (ifc.CTS !== 1'b1 || ifc.count !== 4) begin
      errors++;
      $display("FAIL full_refill: got cts=%b cnt=%0d required 1/4", ifc.CTS, ifc.count);
    end
    for (int v = 2; v <= 5; v++) begin
      checks++;
      if (ifc.Data_out !== v) begin
        errors++;
        $display("FAIL full_drain: got %h required %h", ifc.Data_out, v);
      end
      ifc.read_en_L = 1'b1;
      cyc();
      clear_reads();
    end
    checks++;
    if (dut_vec !== exp_vec() || ifc.empty !== 1'b1) begin
      errors++;
      $display("FAIL full_end: got %h required %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_simul();
    handshake(32'h31);
    handshake(32'h32);
    ifc.DRTS = 1'b1;
    ifc.RX = 32'h33;
    ifc.read_en_N = 1'b1;
    cyc();
    clear_reads();
    ifc.DRTS = 1'b0;
    checks++;
    if (ifc.count !== 2 || ifc.Data_out !== 32'h32 || ifc.CTS !== 1'b1) begin
      errors++;
      $display("FAIL simul_wr_pop: got cnt=%0d data=%h cts=%b required 2/32/1", ifc.count, ifc.Data_out, ifc.CTS);
    end
    cyc();
    ifc.read_en_N = 1'b1;
    cyc();
    clear_reads();
    checks++;
    if (ifc.Data_out !== 32'h33 || ifc.count !== 1) begin
      errors++;
      $display("FAIL simul_order: got data=%h cnt=%0d required 33/1", ifc.Data_out, ifc.count);
    end
    ifc.read_en_N = 1'b1;
    cyc();
    clear_reads();
  endtask

  task automatic test_illegal_pops();
    ifc.read_en_S = 1'b1;
    cyc();
    cyc();
    clear_reads();
    checks++;
    if (ifc.count !== 0 || ifc.empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_pop: got cnt=%0d empty=%b required 0/1", ifc.count, ifc.empty);
    end
    handshake(32'h41);
    handshake(32'h42);
    handshake(32'h43);
    checks++;
    if (ifc.Data_out !== 32'h41 || ifc.count !== 3) begin
      errors++;
      $display("FAIL empty_pop_ptr: got data=%h cnt=%0d required 41/3", ifc.Data_out, ifc.count);
    end
    ifc.read_en_N = 1'b1;
    ifc.read_en_W = 1'b1;
    cyc();
    clear_reads();
    checks++;
    if (ifc.count !== 2 || ifc.Data_out !== 32'h42) begin
      errors++;
      $display("FAIL multi_grant: got cnt=%0d data=%h required 2/42", ifc.count, ifc.Data_out);
    end
    ifc.read_en_S = 1'b1;
    cyc();
    cyc();
    clear_reads();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] got[$];
    int bad;
    for (int i = 0; i < 10; i++) begin
      handshake(32'h10 + i);
      if (i >= 1) begin
        got.push_back(ifc.Data_out);
        ifc.read_en_W = 1'b1;
        cyc();
        clear_reads();
      end
    end
    got.push_back(ifc.Data_out);
    ifc.read_en_W = 1'b1;
    cyc();
    clear_reads();
    bad = 0;
    for (int i = 0; i < 10; i++) if (got[i] !== 32'h10 + i) bad++;
    checks++;
    if (bad != 0 || got.size() != 10 || ifc.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_order: got %0d wrong of %0d popped empty=%b required 0 wrong of 10, empty=1",
               bad, got.size(), ifc.empty);
    end
  endtask

  task automatic test_reset_mid();
    handshake(32'h51);
    handshake(32'h52);
    ifc.DRTS = 1'b1;
    ifc.RX = 32'h53;
    cyc();
    checks++;
    if (ifc.count !== 3 || ifc.CTS !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got cnt=%0d cts=%b required 3/1", ifc.count, ifc.CTS);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ifc.DRTS = 1'b0;
    checks++;
    if (ifc.count !== 0 || ifc.empty !== 1'b1 || ifc.CTS !== 1'b0 || ifc.Data_out !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got cnt=%0d empty=%b cts=%b data=%h required 0/1/0/0",
               ifc.count, ifc.empty, ifc.CTS, ifc.Data_out);
    end
    handshake(32'hBEEF_0000);
    checks++;
    if (ifc.Data_out !== 32'hBEEF_0000 || ifc.count !== 1) begin
      errors++;
      $display("FAIL midrst_rewrite: got data=%h cnt=%0d required beef0000/1", ifc.Data_out, ifc.count);
    end
    ifc.read_en_L = 1'b1;
    cyc();
    clear_reads();
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 600; i++) begin
      if (!ifc.DRTS || ifc.CTS) ifc.RX = $urandom;
      ifc.DRTS = ($urandom_range(0, 3) != 0);
      clear_reads();
      sel = $urandom_range(0, 9);
      case (sel)
        0: ifc.read_en_N = 1'b1;
        1: ifc.read_en_E = 1'b1;
        2: ifc.read_en_W = 1'b1;
        3: ifc.read_en_S = 1'b1;
        4: begin ifc.read_en_L = 1'b1; ifc.read_en_E = 1'b1; end
        default: ;
      endcase
      rst = ($urandom_range(0, 99) == 0);
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
    rst = 1'b0;
    ifc.DRTS = 1'b0;
    clear_reads();
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cts = 1'b0;
    rst = 1'b1;
    ifc.DRTS = 1'b0;
    ifc.RX = '0;
    clear_reads();
    test_reset();
    test_single_flit();
    test_fill_full();
    test_simul();
    test_illegal_pops();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_input_fifo.md
# noc_input_fifo

Per-port input buffer of the 5-port mesh router. It sits directly upstream of the per-output-port round-robin arbiters. It accepts flits from the neighbouring router (or local PE) over an RTS/CTS link handshake and stores them in a circular FIFO. Each flit is popped when one of the five output-port arbiters grants this input.

## Interface
- DATA_WIDTH, 32, flit width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- RX  input  DATA_WIDTH  incoming flit; stable while DRTS=1
- DRTS  input  1  upstream request-to-send
- CTS  output  1  clear-to-send pulse back to upstream (registered)
- read_en_N/E/W/S/L  input  1 each  pop requests; these are the grant outputs of the N/E/W/S/L output arbiters for this input
- Data_out  output  DATA_WIDTH  head-of-FIFO flit
- empty  output  1  FIFO holds 0 flits
- full  output  1  FIFO holds DEPTH flits
- count  output  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH×DATA_WIDTH array, read_ptr and write_ptr of $clog2(DEPTH) bits, count register. Pointers wrap modulo DEPTH by natural overflow.
- Handshake FSM, 2 states:
  - WAIT (CTS=0) -> ACK when DRTS=1 and full=0. On that same edge, RX is written at write_ptr and write_ptr increments.
  - WAIT stays in WAIT when DRTS=0 or full=1. No write occurs.
  - ACK (CTS=1) -> WAIT unconditionally, with no write. This prevents a double write while upstream still holds DRTS during the CTS cycle.
  - Maximum write rate is 1 flit per 2 cycles, which matches the upstream RTS drop/re-raise behaviour.
- Read:
  - pop = (read_en_N|read_en_E|read_en_W|read_en_S|read_en_L) & ~empty.
  - On pop, read_ptr increments.
  - Multiple read_en asserted together count as a single pop, since the arbiters guarantee one-hot.
  - A pop while empty is ignored.
- Count:
  - write only: +1; pop only: −1; both on the same edge: unchanged.
- Flags:
  - empty = (count==0); full = (count==DEPTH). Both decode combinationally from the registered count.
  - Full is evaluated on the current count. A simultaneous pop does not allow a write into a full FIFO that cycle.
- Data_out:
  - mem[read_ptr] when not empty; all-zeros when empty.
  - Combinational from registered state, so there is no same-cycle bypass from RX.

## Timing
- Reset (edge with rst=1): FSM=WAIT, CTS=0, read_ptr=write_ptr=0, count=0, empty=1, full=0, Data_out=0. Memory contents are not cleared.
- Reset mid-operation:
  - All buffered flits are discarded and CTS drops on the next edge.
  - A write pending on the reset edge is not performed.
- Write latency:
  - DRTS sampled high at edge k (WAIT, not full): CTS=1 during cycle k→k+1.
  - Flit is visible on Data_out and empty=0 from edge k, when the FIFO was empty.
- Read latency: pop sampled at edge k; the next flit (or Data_out=0/empty=1) is presented after edge k.
- Full boundary:
  - With DRTS held high and full=1, CTS stays 0.
  - The first edge after a pop frees an entry enables the write, so CTS rises one cycle after the pop edge.
- Wrap-around: after DEPTH writes, write_ptr returns to 0. Ordering is strictly FIFO across the wrap.

## Test plan
- Single flit:
  - Stimulus: DRTS=1, RX=0xA5A5_0001 for 2 cycles, then DRTS=0.
  - Required: CTS high exactly 1 cycle; count=1, empty=0, Data_out=0xA5A5_0001.
  - Then read_en_E=1 for 1 cycle -> empty=1, Data_out=0, count=0.
- Fill to full:
  - Stimulus: 4 handshakes with RX=1,2,3,4, then DRTS held high with RX=5.
  - Required: full=1, count=4, CTS stays 0 for ≥10 cycles.
  - Then read_en_L pulse -> Data_out 1→2, and CTS rises on the following cycle, writing 5.
- Simultaneous write and pop:
  - Stimulus: with count=2, a write edge coincides with read_en_N=1.
  - Required: count stays 2; read order preserved.
- Wrap-around:
  - Stimulus: 10 flits 0x10..0x19 streamed with interleaved single pops.
  - Required: popped sequence exactly 0x10..0x19; no loss or duplicate.
- Illegal pops:
  - Stimulus: read_en_S=1 while empty.
  - Required: no pointer change, count=0.
  - Stimulus: read_en_N=read_en_W=1 with count=3.
  - Required: count=2 (single pop).
- Reset mid-stream:
  - Stimulus: count=3 and CTS=1, then rst=1 for 1 cycle.
  - Required: count=0, empty=1, CTS=0, Data_out=0 after the edge.
  - Required: the next handshake writes to entry 0 and reads back correctly.
